motor_cmd_tx: RTL and testbench

MOTOR_CMD_TX -- requirements
Module: motor_cmd_tx

---
 rtl/lcd_inst_pkg.sv | 21 ++
 rtl/motor_cmd_pkg.sv | 21 ++
 rtl/uart_tx.sv | 46 ++++
 rtl/motor_cmd_tx.sv | 158 +++++++++++++++
 tb/tb_motor_cmd_tx.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_inst_pkg.sv
// Shared character and instruction constants for the text-output blocks
// (LCD controller and serial command formatters).
package lcd_inst_pkg;

  localparam logic [7:0] LCD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_HOME    = 8'h02;

  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_QUOTE    = 8'h22;
  localparam logic [7:0] CH_COMMA    = 8'h2C;
  localparam logic [7:0] CH_MINUS    = 8'h2D;
  localparam logic [7:0] CH_PERIOD   = 8'h2E;
  localparam logic [7:0] CH_0        = 8'h30;
  localparam logic [7:0] CH_COLON    = 8'h3A;
  localparam logic [7:0] CH_L        = 8'h4C;
  localparam logic [7:0] CH_R        = 8'h52;
  localparam logic [7:0] CH_T        = 8'h54;
  localparam logic [7:0] CH_LBRACE   = 8'h7B;
  localparam logic [7:0] CH_RBRACE   = 8'h7D;

endpackage

// File: rtl/motor_cmd_pkg.sv
// Types and constants for the motor command serialiser.
package motor_cmd_pkg;
  import lcd_inst_pkg::*;

  typedef enum logic [1:0] {IDLE, FORMAT, SEND, DRAIN} state_t;

  localparam int SPEED_MAX     = 100;
  localparam int MSG_MAX_BYTES = 28;
  localparam int MSG_MIN_BYTES = 26;

  // Right-justified speed text: 5 bytes when negative, else 4 with a zero top byte.
  function automatic logic [39:0] speed_field(input logic neg, input logic [6:0] mag);
    logic [7:0] d_int, d_ten, d_one;
    d_int = CH_0 + 8'(mag / 7'd100);
    d_ten = CH_0 + 8'((mag % 7'd100) / 7'd10);
    d_one = CH_0 + 8'(mag % 7'd10);
    if (neg) return {CH_MINUS, d_int, CH_PERIOD, d_ten, d_one};
    return {8'h00, d_int, CH_PERIOD, d_ten, d_one};
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; ready is high whenever no frame is on the line.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [9:0]    sh;
  logic [CW-1:0] ccnt;
  logic [3:0]    bitn;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      sh     <= '1;
      ccnt   <= '0;
      bitn   <= '0;
    end else if (!active) begin
      if (valid) begin
        sh     <= {1'b1, data, 1'b0};
        active <= 1'b1;
        ccnt   <= '0;
        bitn   <= '0;
      end
    end else if (ccnt == LAST) begin
      ccnt <= '0;
      sh   <= {1'b1, sh[9:1]};
      if (bitn == 4'd9) active <= 1'b0;
      else              bitn   <= bitn + 4'd1;
    end else begin
      ccnt <= ccnt + 1'b1;
    end
  end

  assign ready = !active;
  assign tx    = active ? sh[0] : 1'b1;

endmodule

// File: rtl/motor_cmd_tx.sv
// Formats a left/right wheel command as a JSON line and sends it over UART.
// Optional periodic resend of the last command: define MOTOR_CMD_HEARTBEAT_EN.
module motor_cmd_tx
  import lcd_inst_pkg::*, motor_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
  parameter int SPEED_W      = 8,
  parameter int T_CODE       = 1,
  parameter int HB_CYCLES    = 25_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  input  logic signed [SPEED_W-1:0] cmd_left,
  input  logic signed [SPEED_W-1:0] cmd_right,
  output logic                      cmd_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      uart_out
);
  localparam int MSG_BITS = 8 * MSG_MAX_BYTES;
  localparam int IDX_W    = $clog2(MSG_MAX_BYTES);
  localparam logic [7:0] T_DIGIT = CH_0 + 8'(T_CODE);
  typedef logic [IDX_W-1:0] idx_t;

  if (T_CODE < 0 || T_CODE > 9 || HB_CYCLES < 1 || SPEED_W < 8 || CLKS_PER_BIT < 1) begin : g_bad_cfg
    $error("motor_cmd_tx: unsupported parameter set");
  end

  state_t                    state, state_d;
  logic signed [SPEED_W-1:0] left_q, right_q;
  logic [MSG_BITS-1:0]       msg_q, msg_d;
  idx_t                      len_q, len_d, idx_q, byte_sel;
  logic [7:0]                ls, rs;
  logic [39:0]               lf, rf;
  logic                      accept, hb_fire;
  logic                      uart_valid, uart_ready;
  logic [7:0]                uart_data;

  // Returns {negative, magnitude} after clamping to +/-SPEED_MAX.
  function automatic logic [7:0] saturate(input logic signed [SPEED_W-1:0] v);
    int s;
    s = int'(v);
    if (s > SPEED_MAX)       s = SPEED_MAX;
    else if (s < -SPEED_MAX) s = -SPEED_MAX;
    return {s < 0, 7'(s < 0 ? -s : s)};
  endfunction

  // Message is assembled right-justified by shifting in variable-length fields;
  // byte 0 of the line therefore sits at byte position len-1.
  always_comb begin
    ls    = saturate(left_q);
    rs    = saturate(right_q);
    lf    = speed_field(ls[7], ls[6:0]);
    rf    = speed_field(rs[7], rs[6:0]);
    msg_d = MSG_BITS'({CH_LBRACE, CH_QUOTE, CH_T, CH_QUOTE, CH_COLON, T_DIGIT,
                       CH_COMMA, CH_QUOTE, CH_L, CH_QUOTE, CH_COLON});
    msg_d = (msg_d << (ls[7] ? 40 : 32)) | MSG_BITS'(lf);
    msg_d = (msg_d << 40) | MSG_BITS'({CH_COMMA, CH_QUOTE, CH_R, CH_QUOTE, CH_COLON});
    msg_d = (msg_d << (rs[7] ? 40 : 32)) | MSG_BITS'(rf);
    msg_d = (msg_d << 16) | MSG_BITS'({CH_RBRACE, CH_LF});
    len_d = idx_t'(MSG_MIN_BYTES) + idx_t'(ls[7]) + idx_t'(rs[7]);
  end

  assign byte_sel  = len_q - idx_q - 1'b1;
  assign uart_data = msg_q[{byte_sel, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    uart_valid = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = FORMAT;
        end else if (hb_fire) begin
          state_d = FORMAT;
        end
      end
      FORMAT: state_d = SEND;
      SEND: begin
        uart_valid = 1'b1;
        if (uart_ready && idx_q == len_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        if (uart_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      left_q  <= '0;
      right_q <= '0;
      msg_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      if (accept) begin
        left_q  <= cmd_left;
        right_q <= cmd_right;
      end
      if (state == FORMAT) begin
        msg_q <= msg_d;
        len_q <= len_d;
        idx_q <= '0;
      end else if (state == SEND && uart_ready) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef MOTOR_CMD_HEARTBEAT_EN
  localparam int HB_W = $clog2(HB_CYCLES + 1);
  logic [HB_W-1:0] hb_cnt;
  logic            have_cmd;

  // Counter only runs in IDLE, so leaving IDLE (accept, resend) and done both restart it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt   <= '0;
      have_cmd <= 1'b0;
    end else begin
      if (accept) have_cmd <= 1'b1;
      if (state != IDLE || accept) hb_cnt <= '0;
      else                         hb_cnt <= hb_cnt + 1'b1;
    end
  end

  assign hb_fire = have_cmd && (hb_cnt == HB_W'(HB_CYCLES - 1));
`else
  assign hb_fire = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk   (clk),
    .rst   (rst),
    .valid (uart_valid),
    .data  (uart_data),
    .ready (uart_ready),
    .tx    (uart_out)
  );

endmodule

// File: tb/tb_motor_cmd_tx.sv
// Self-checking bench for motor_cmd_tx: decodes the serial line and compares
// each line against a string-level model of the message format.
module tb_motor_cmd_tx;
  localparam int CPB    = 4;
  localparam int SW     = 8;
  localparam int TC     = 1;
  localparam int HB     = 1000;
  localparam int FRAME  = 10 * CPB;
  localparam int MSG_TO = 28 * FRAME + 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic signed [SW-1:0] cmd_left = '0, cmd_right = '0;
  logic          cmd_ready, busy, done, uart_out;

  motor_cmd_tx #(.CLKS_PER_BIT(CPB), .SPEED_W(SW), .T_CODE(TC), .HB_CYCLES(HB)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .cmd_ready(cmd_ready), .busy(busy), .done(done), .uart_out(uart_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  logic [7:0] rx_q[$];
  int start_q[$];
  int frame_err = 0;
  int done_cnt = 0, done_cyc = 0;

  // Serial line decoder: samples mid-bit, logs the cycle of each start bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_out === 1'b0) begin
        start_q.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_out;
        end
        repeat (CPB) @(negedge clk);
        if (uart_out !== 1'b1) frame_err++;
        rx_q.push_back(b);
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end

  // Reference model: the line as text.
  function automatic string spd(int v);
    int s, m;
    string sign;
    s = (v > 100) ? 100 : ((v < -100) ? -100 : v);
    m = (s < 0) ? -s : s;
    sign = "";
    if (s < 0) sign = "-";
    return {sign, $sformatf("%0d.%02d", m / 100, m % 100)};
  endfunction

  function automatic string expect_msg(int l, int r);
    return $sformatf("{\"T\":%0d,\"L\":%s,\"R\":%s}\n", TC, spd(l), spd(r));
  endfunction

  function automatic string rx_string();
    string s = "";
    foreach (rx_q[i]) s = {s, $sformatf("%c", rx_q[i])};
    return s;
  endfunction

  function automatic string vis(string s);
    string o = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) o = {o, "~"};
      else o = {o, $sformatf("%c", s[i])};
    end
    return o;
  endfunction

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
    frame_err = 0;
  endtask

  task automatic send_cmd(input int l, input int r, output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < MSG_TO; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    cmd_left  = SW'(l);
    cmd_right = SW'(r);
    cmd_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (uart_out !== 1'b1) begin miscompares++; $display("FAIL reset_uart_out got %b want 1", uart_out); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_negative();
    string exp, got;
    int acc, d0, maxgap, last;
    bit ok1, ok2;
    exp = expect_msg(-50, -50);
    clear_rx();
    d0 = done_cnt;
    send_cmd(-50, -50, acc, ok1);
    wait_done(d0, MSG_TO, ok2);
    got = rx_string();
    vectors++; if (!(ok1 && ok2)) begin miscompares++; $display("FAIL neg_timeout accepted %0d done %0d want 1 1", ok1, ok2); end
    vectors++; if (got != exp) begin miscompares++; $display("FAIL neg_text got \"%s\" want \"%s\"", vis(got), vis(exp)); end
    vectors++; if (got.len() != 28) begin miscompares++; $display("FAIL neg_len got %0d want 28", got.len()); end
    vectors++; if (start_q.size() == 0 || start_q[0] - acc > 2) begin miscompares++;
      $display("FAIL neg_latency got %0d want <=2", start_q.size() ? start_q[0] - acc : -1); end
    maxgap = 0;
    for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] > maxgap) maxgap = start_q[i] - start_q[i-1];
    vectors++; if (maxgap > FRAME + 1) begin miscompares++; $display("FAIL neg_gap got %0d want <=%0d", maxgap, FRAME + 1); end
    last = start_q.size() ? start_q[start_q.size()-1] : 0;
    vectors++; if (done_cyc - last < FRAME || done_cyc - last > FRAME + 1) begin miscompares++;
      $display("FAIL neg_done_time got %0d want %0d..%0d", done_cyc - last, FRAME, FRAME + 1); end
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL neg_ready_after got %b want 1", cmd_ready); end
    repeat (5) @(negedge clk);
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL neg_done_pulses got %0d want 1", done_cnt - d0); end
    vectors++; if (frame_err != 0) begin miscompares++; $display("FAIL neg_framing got %0d want 0", frame_err); end
  endtask

  task automatic test_positive();
    string exp, got;
    int acc, d0;
    bit ok1, ok2;
    exp = expect_msg(100, 0);
    clear_rx();
    d0 = done_cnt;
    send_cmd(100, 0, acc, ok1);
    wait_done(d0, MSG_TO, ok2);
    got = rx_string();
    vectors++; if (!(ok1 && ok2)) begin miscompares++; $display("FAIL pos_timeout accepted %0d done %0d want 1 1", ok1, ok2); end
    vectors++; if (got != exp) begin miscompares++; $display("FAIL pos_text got \"%s\" want \"%s\"", vis(got), vis(exp)); end
    vectors++; if (got.len() != 26) begin miscompares++; $display("FAIL pos_len got %0d want 26", got.len()); end
  endtask

  task automatic test_saturate();
    string exp, got;
    int acc, d0;
    bit ok1, ok2;
    exp = expect_msg(127, -128);
    clear_rx();
    d0 = done_cnt;
    send_cmd(127, -128, acc, ok1);
    wait_done(d0, MSG_TO, ok2);
    got = rx_string();
    vectors++; if (!(ok1 && ok2)) begin miscompares++; $display("FAIL sat_timeout accepted %0d done %0d want 1 1", ok1, ok2); end
    vectors++; if (got != exp) begin miscompares++; $display("FAIL sat_text got \"%s\" want \"%s\"", vis(got), vis(exp)); end
  endtask

  task automatic test_random();
    int tl[4] = '{-1, -100, 99, 101};
    int tr[4] = '{1, -101, -99, 0};
    for (int k = 0; k < 10; k++) begin
      string exp, got;
      int l, r, acc, d0;
      bit ok1, ok2;
      if (k < 4) begin l = tl[k]; r = tr[k]; end
      else begin l = int'($urandom_range(255)) - 128; r = int'($urandom_range(255)) - 128; end
      exp = expect_msg(l, r);
      clear_rx();
      d0 = done_cnt;
      send_cmd(l, r, acc, ok1);
      wait_done(d0, MSG_TO, ok2);
      got = rx_string();
      vectors++; if (!(ok1 && ok2) || got != exp) begin miscompares++;
        $display("FAIL rand_text l=%0d r=%0d got \"%s\" want \"%s\"", l, r, vis(got), vis(exp)); end
    end
  endtask

  task automatic test_busy_ignore();
    string exp, got;
    int acc, d0;
    bit ok1, ok2;
    exp = expect_msg(-50, 30);
    clear_rx();
    d0 = done_cnt;
    send_cmd(-50, 30, acc, ok1);
    for (int i = 0; i < MSG_TO && start_q.size() < 5; i++) @(negedge clk);
    vectors++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin miscompares++;
      $display("FAIL busy_flags got ready=%b busy=%b want 0 1", cmd_ready, busy); end
    cmd_left = SW'(7); cmd_right = SW'(7); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(d0, MSG_TO, ok2);
    repeat (3 * FRAME + 20) @(negedge clk);
    got = rx_string();
    vectors++; if (!(ok1 && ok2) || got != exp) begin miscompares++;
      $display("FAIL busy_text got \"%s\" want \"%s\"", vis(got), vis(exp)); end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL busy_done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    string exp, got;
    int acc, d0;
    bit ok1, ok2, ok3, ok4;
    exp = {expect_msg(-3, 45), expect_msg(60, -77)};
    clear_rx();
    d0 = done_cnt;
    send_cmd(-3, 45, acc, ok1);
    wait_done(d0, MSG_TO, ok2);
    send_cmd(60, -77, acc, ok3);
    wait_done(d0 + 1, MSG_TO, ok4);
    got = rx_string();
    vectors++; if (!(ok1 && ok2 && ok3 && ok4) || got != exp) begin miscompares++;
      $display("FAIL b2b_text got \"%s\" want \"%s\"", vis(got), vis(exp)); end
  endtask

  task automatic test_rst_mid();
    int acc, n0, d0;
    bit ok1;
    clear_rx();
    send_cmd(-25, -75, acc, ok1);
    for (int i = 0; i < MSG_TO && start_q.size() < 12; i++) @(negedge clk);
    repeat (CPB * 3) @(negedge clk);
    vectors++; if (uart_out !== 1'b0 && uart_out !== 1'b1) begin miscompares++; $display("FAIL rst_line_known got %b", uart_out); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (uart_out !== 1'b1) begin miscompares++; $display("FAIL rst_mid_uart_out got %b want 1", uart_out); end
    vectors++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++;
      $display("FAIL rst_mid_flags got ready=%b busy=%b want 1 0", cmd_ready, busy); end
    rst = 1'b0;
    n0 = start_q.size();
    d0 = done_cnt;
    repeat (4 * FRAME + 200) @(negedge clk);
    vectors++; if (!ok1 || n0 != 12 || start_q.size() != n0) begin miscompares++;
      $display("FAIL rst_mid_quiet got starts %0d then %0d want 12 12", n0, start_q.size()); end
    vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL rst_mid_done got %0d want %0d", done_cnt, d0); end
    clear_rx();
  endtask

`ifdef MOTOR_CMD_HEARTBEAT_EN
  task automatic test_heartbeat();
    string exp, got;
    int acc, d0, dprev;
    bit ok1, ok2;
    exp = expect_msg(-37, 88);
    clear_rx();
    d0 = done_cnt;
    send_cmd(-37, 88, acc, ok1);
    wait_done(d0, MSG_TO, ok2);
    vectors++; if (!(ok1 && ok2)) begin miscompares++; $display("FAIL hb_first accepted %0d done %0d want 1 1", ok1, ok2); end
    for (int k = 1; k <= 2; k++) begin
      dprev = done_cyc;
      clear_rx();
      wait_done(d0 + k, HB + MSG_TO, ok2);
      got = rx_string();
      vectors++; if (!ok2 || got != exp) begin miscompares++;
        $display("FAIL hb_text k=%0d got \"%s\" want \"%s\"", k, vis(got), vis(exp)); end
      vectors++; if (start_q.size() == 0 || start_q[0] - dprev < HB || start_q[0] - dprev > HB + 4) begin miscompares++;
        $display("FAIL hb_interval k=%0d got %0d want %0d..%0d", k, start_q.size() ? start_q[0] - dprev : -1, HB, HB + 4); end
    end
  endtask
`else
  task automatic test_quiet_line();
    int acc, d0;
    bit ok1, ok2;
    clear_rx();
    d0 = done_cnt;
    send_cmd(12, -34, acc, ok1);
    wait_done(d0, MSG_TO, ok2);
    clear_rx();
    repeat (HB + 200) @(negedge clk);
    vectors++; if (!(ok1 && ok2) || start_q.size() != 0) begin miscompares++;
      $display("FAIL quiet_line got %0d starts want 0", start_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_negative();
    test_positive();
    test_saturate();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_rst_mid();
`ifdef MOTOR_CMD_HEARTBEAT_EN
    test_heartbeat();
`else
    test_quiet_line();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
